// File: rtl/csr_pkg.sv
// Constants and state encoding shared by the CSR encoder and the entry streamer.
package csr_pkg;
   localparam int IMAGE_SIZE         = 28;
   localparam int MAX_ENTRIES        = IMAGE_SIZE * IMAGE_SIZE;
   localparam int COL_LENGTH         = 8;
   localparam int WORD_LENGTH        = 8;
   localparam int DOUBLE_WORD_LENGTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM,
      WAIT_LOW
   } csr_state_t;
endpackage

// File: rtl/csr_entry_mux.sv
// Combinational select of one (value, col, row) entry from the flattened snapshot arrays.
module csr_entry_mux
   import csr_pkg::*;
#(
   parameter int col_length         = COL_LENGTH,
   parameter int word_length        = WORD_LENGTH,
   parameter int double_word_length = DOUBLE_WORD_LENGTH,
   parameter int image_size         = IMAGE_SIZE
) (
   input  logic [image_size*image_size*word_length-1:0] data,
   input  logic [image_size*image_size*col_length-1:0]  cols,
   input  logic [image_size*image_size*col_length-1:0]  rows,
   input  logic [double_word_length-1:0]                idx,
   output logic [word_length-1:0]                       value,
   output logic [col_length-1:0]                        col,
   output logic [col_length-1:0]                        row
);
   localparam int max_entries = image_size * image_size;
   localparam int sel_w       = $clog2(max_entries);

   logic [word_length-1:0] value_arr [max_entries];
   logic [col_length-1:0]  col_arr   [max_entries];
   logic [col_length-1:0]  row_arr   [max_entries];
   logic [sel_w-1:0]       sel;

   generate
      for (genvar gi = 0; gi < max_entries; gi++) begin : g_unpack
         assign value_arr[gi] = data[gi*word_length +: word_length];
         assign col_arr[gi]   = cols[gi*col_length +: col_length];
         assign row_arr[gi]   = rows[gi*col_length +: col_length];
      end
   endgenerate

   assign sel = idx[sel_w-1:0];

   // Slots past the array end read as zero instead of aliasing a low slot.
   always_comb begin
      value = '0;
      col   = '0;
      row   = '0;
      if (idx < double_word_length'(max_entries)) begin
         value = value_arr[sel];
         col   = col_arr[sel];
         row   = row_arr[sel];
      end
   end
endmodule

// File: rtl/csr_entry_streamer.sv
// Snapshots a CSR frame and replays its entries one per cycle over valid/ready.
// Optional CSR_BOUNDS_CHECK_EN: skip entries with col/row >= image_size and count them.
module csr_entry_streamer
   import csr_pkg::*;
#(
   parameter int col_length         = COL_LENGTH,
   parameter int word_length        = WORD_LENGTH,
   parameter int double_word_length = DOUBLE_WORD_LENGTH,
   parameter int image_size         = IMAGE_SIZE
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   input  logic [image_size*image_size*word_length-1:0] data_in,
   input  logic [image_size*image_size*col_length-1:0]  cols_in,
   input  logic [image_size*image_size*col_length-1:0]  rows_in,
   input  logic [double_word_length-1:0]                valid_num_in,
   input  logic                                         out_ready,
   output logic                                         out_valid,
   output logic [word_length-1:0]                       value_out,
   output logic [col_length-1:0]                        col_out,
   output logic [col_length-1:0]                        row_out,
   output logic                                         last_out,
   output logic                                         busy,
   output logic                                         done
`ifdef CSR_BOUNDS_CHECK_EN
   ,
   output logic [7:0]                                   drop_count
`endif
);
   localparam int                          max_entries = image_size * image_size;
   localparam logic [double_word_length-1:0] max_count = double_word_length'(max_entries);

   csr_state_t                                 state_reg;
   logic                                       armed_reg;
   logic [double_word_length-1:0]              idx_reg;
   logic [double_word_length-1:0]              count_reg;
   logic [max_entries*word_length-1:0]         data_snap_reg;
   logic [max_entries*col_length-1:0]          cols_snap_reg;
   logic [max_entries*col_length-1:0]          rows_snap_reg;

   logic [word_length-1:0] mux_value;
   logic [col_length-1:0]  mux_col;
   logic [col_length-1:0]  mux_row;
   logic                   last_entry;
   logic                   entry_bad;

   csr_entry_mux #(
      .col_length         (col_length),
      .word_length        (word_length),
      .double_word_length (double_word_length),
      .image_size         (image_size)
   ) u_mux (
      .data  (data_snap_reg),
      .cols  (cols_snap_reg),
      .rows  (rows_snap_reg),
      .idx   (idx_reg),
      .value (mux_value),
      .col   (mux_col),
      .row   (mux_row)
   );

   assign last_entry = (idx_reg == count_reg - double_word_length'(1));

`ifdef CSR_BOUNDS_CHECK_EN
   assign entry_bad = (mux_col >= col_length'(image_size)) || (mux_row >= col_length'(image_size));
`else
   assign entry_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         armed_reg     <= 1'b1;
         idx_reg       <= '0;
         count_reg     <= '0;
         data_snap_reg <= '0;
         cols_snap_reg <= '0;
         rows_snap_reg <= '0;
         out_valid     <= 1'b0;
         value_out     <= '0;
         col_out       <= '0;
         row_out       <= '0;
         last_out      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef CSR_BOUNDS_CHECK_EN
         drop_count    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (in_valid && armed_reg) begin
                  data_snap_reg <= data_in;
                  cols_snap_reg <= cols_in;
                  rows_snap_reg <= rows_in;
                  count_reg     <= (valid_num_in > max_count) ? max_count : valid_num_in;
                  armed_reg     <= 1'b0;
                  state_reg     <= LOAD;
`ifdef CSR_BOUNDS_CHECK_EN
                  drop_count    <= '0;
`endif
               end
            end
            LOAD: begin
               idx_reg <= '0;
               if (count_reg == '0) begin
                  done      <= 1'b1;
                  state_reg <= WAIT_LOW;
               end else begin
                  busy      <= 1'b1;
                  state_reg <= STREAM;
               end
            end
            STREAM: begin
               if (out_valid && out_ready && last_out) begin
                  out_valid <= 1'b0;
                  last_out  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= WAIT_LOW;
               end else if (!out_valid || out_ready) begin
                  // Output slot is free: fetch entry idx (or skip it) for the next cycle.
                  idx_reg <= idx_reg + double_word_length'(1);
                  if (entry_bad) begin
                     out_valid <= 1'b0;
                     last_out  <= 1'b0;
`ifdef CSR_BOUNDS_CHECK_EN
                     if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
`endif
                     if (last_entry) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= WAIT_LOW;
                     end
                  end else begin
                     out_valid <= 1'b1;
                     value_out <= mux_value;
                     col_out   <= mux_col;
                     row_out   <= mux_row;
                     last_out  <= last_entry;
                  end
               end
            end
            WAIT_LOW: begin
               if (!in_valid) begin
                  armed_reg <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_entry_streamer.sv
// Randomized self-checking bench for csr_entry_streamer against a queue-based frame model.
module tb_csr_entry_streamer;
   import csr_pkg::*;

   localparam int N = MAX_ENTRIES;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [N*8-1:0]    data_in = '0;
   logic [N*8-1:0]    cols_in = '0;
   logic [N*8-1:0]    rows_in = '0;
   logic [15:0]       valid_num_in = '0;
   logic              out_valid;
   logic [7:0]        value_out;
   logic [7:0]        col_out;
   logic [7:0]        row_out;
   logic              last_out;
   logic              busy;
   logic              done;
`ifdef CSR_BOUNDS_CHECK_EN
   logic [7:0]        drop_count;
`endif
   logic [24:0]       bus;

   int checks = 0;
   int failures = 0;
   logic [7:0] ev [N];
   logic [7:0] ec [N];
   logic [7:0] er [N];

   csr_entry_streamer dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .data_in      (data_in),
      .cols_in      (cols_in),
      .rows_in      (rows_in),
      .valid_num_in (valid_num_in),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .value_out    (value_out),
      .col_out      (col_out),
      .row_out      (row_out),
      .last_out     (last_out),
      .busy         (busy),
      .done         (done)
`ifdef CSR_BOUNDS_CHECK_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   assign bus = {value_out, col_out, row_out, last_out};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit kept(input int i);
`ifdef CSR_BOUNDS_CHECK_EN
      return (ec[i] < 8'(IMAGE_SIZE)) && (er[i] < 8'(IMAGE_SIZE));
`else
      return (i >= 0);
`endif
   endfunction

   task automatic fill_random(input int bad_pct);
      for (int i = 0; i < N; i++) begin
         ev[i] = 8'($urandom_range(0, 255));
         ec[i] = ($urandom_range(0, 99) < bad_pct) ? 8'($urandom_range(28, 255)) : 8'($urandom_range(0, 27));
         er[i] = ($urandom_range(0, 99) < bad_pct) ? 8'($urandom_range(28, 255)) : 8'($urandom_range(0, 27));
      end
   endtask

   task automatic pack_table();
      for (int i = 0; i < N; i++) begin
         data_in[i*8 +: 8] = ev[i];
         cols_in[i*8 +: 8] = ec[i];
         rows_in[i*8 +: 8] = er[i];
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: stall the 2nd entry for 3 cycles.
   task automatic run_frame(input int n, input int mode, input int abort_at,
                            output int first_valid, output int done_at, output int xfers);
      logic [24:0] exp_q[$];
      logic [24:0] prev_bus = '0;
      logic        prev_valid = 1'b0;
      logic        prev_ready = 1'b0;
      int          cnt = (n > N) ? N : n;
      int          drops = 0;
      int          stall = 0;
      bit          got_done = 0;
      first_valid = -1;
      done_at = -1;
      xfers = 0;
      for (int i = 0; i < cnt; i++) begin
         if (kept(i)) exp_q.push_back({ev[i], ec[i], er[i], 1'(i == cnt - 1)});
         else drops++;
      end
      pack_table();
      @(negedge clk);
      valid_num_in = 16'(n);
      in_valid = 1'b1;
      for (int j = 0; j < 4000 && !got_done; j++) begin
         @(negedge clk);
         if (abort_at >= 0 && xfers == abort_at && out_valid) begin
            rst = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            check("abort_outputs", {bus, out_valid, busy, done}, '0);
            rst = 1'b0;
            $display("frame n=%0d aborted after %0d transfers", n, xfers);
            return;
         end
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", bus, prev_bus);
         end
         if (out_valid && first_valid < 0) first_valid = j;
         if (done) begin
            got_done = 1;
            done_at = j;
            check("done_valid_low", 32'(out_valid), 0);
            check("drain_left", exp_q.size(), 0);
`ifdef CSR_BOUNDS_CHECK_EN
            check("drop_count", 32'(drop_count), (drops > 255) ? 255 : drops);
`endif
         end
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               out_ready = !(xfers == 1 && stall < 3 && out_valid);
               if (!out_ready) stall++;
            end
         endcase
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_xfer", 1, 0);
            else check("xfer", bus, exp_q.pop_front());
            xfers++;
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_bus = bus;
         if (j == 3) begin
            for (int i = 0; i < N; i++) begin
               data_in[i*8 +: 8] = 8'($urandom);
               cols_in[i*8 +: 8] = 8'($urandom);
               rows_in[i*8 +: 8] = 8'($urandom);
            end
         end
         if (n >= 8 && j == 4) in_valid = 1'b0;
         if (n >= 8 && j == 5) in_valid = 1'b1;
      end
      if (!got_done) check("timeout", 0, 1);
      $display("frame n=%0d mode=%0d xfers=%0d first_valid=%0d done_at=%0d drops=%0d",
               n, mode, xfers, first_valid, done_at, drops);
   endtask

   task automatic set_directed();
      fill_random(0);
      ev[0] = 8'd5; ec[0] = 8'd2;  er[0] = 8'd0;
      ev[1] = 8'd9; ec[1] = 8'd27; er[1] = 8'd0;
      ev[2] = 8'd1; ec[2] = 8'd0;  er[2] = 8'd27;
   endtask

   initial begin
      int fv, da, nx;
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus, out_valid, busy, done}, '0);
`ifdef CSR_BOUNDS_CHECK_EN
      check("reset_drop", 32'(drop_count), 0);
`endif
      rst = 1'b0;

      set_directed();
      run_frame(3, 0, -1, fv, da, nx);
      check("f1_first_valid", fv, 2);
      check("f1_done_at", da, 5);
      check("f1_xfers", nx, 3);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("no_retrigger", {out_valid, busy, done}, 0);
      end
      in_valid = 1'b0;

      set_directed();
      run_frame(3, 2, -1, fv, da, nx);
      check("f2_done_at", da, 8);
      check("f2_xfers", nx, 3);
      in_valid = 1'b0;

      run_frame(0, 0, -1, fv, da, nx);
      check("f3_done_at", da, 1);
      check("f3_no_valid", fv, -1);
      in_valid = 1'b0;

      fill_random(0);
      run_frame(900, 0, -1, fv, da, nx);
      check("f4_xfers", nx, 784);
      check("f4_done_at", da, 786);
      in_valid = 1'b0;

      fill_random(0);
      run_frame(50, 0, 10, fv, da, nx);
      check("f5_abort_xfers", nx, 10);

      set_directed();
      ec[1] = 8'd30;
      run_frame(3, 0, -1, fv, da, nx);
`ifdef CSR_BOUNDS_CHECK_EN
      check("f6_xfers", nx, 2);
`else
      check("f6_xfers", nx, 3);
`endif
      in_valid = 1'b0;

      repeat (8) begin
         fill_random(15);
         run_frame($urandom_range(0, 60), 1, -1, fv, da, nx);
         in_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
